// File: rtl/des_pkg.sv
// des_pkg: shared definitions for the DES round sequencer.
//   - state codes (exported on the S debug port)
//   - default round count
//   - encrypt key shift table and the decrypt rotate derived from it
package des_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_ROUND  = 3'd2,
    S_FINISH = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd7
  } state_t;

  localparam int NUM_ROUNDS_DEF = 16;

  // Entry i = left shift applied to C/D before round i.
  // Listed MSB first, so index 15 is written first.
  localparam logic [15:0][1:0] ENC_SHIFT = {
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1,
    2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1
  };

  function automatic logic [1:0] enc_rot(input int idx);
    if (idx < 0 || idx > 15) return 2'd0;
    return ENC_SHIFT[idx];
  endfunction

  // Decrypt walks the key schedule backwards: round 0 uses K16, which is
  // the PC1 key itself after a full 28-bit cycle of shifts, so no rotate.
  // Round i then undoes the shift that produced K(17-i).
  function automatic logic [1:0] dec_rot(input int idx);
    if (idx <= 0 || idx > 15) return 2'd0;
    return ENC_SHIFT[16 - idx];
  endfunction

endpackage

// File: rtl/des_key_sched_rom.sv
// des_key_sched_rom: combinational per-round key rotate schedule.
//   round_idx  in   current round, 0-based
//   mode       in   1 = decrypt, 0 = encrypt
//   active     in   high only while rounds are running; outputs 0 otherwise
//   rot_amt    out  rotate amount 0..2
//   rot_right  out  1 = rotate right (decrypt)
module des_key_sched_rom
  import des_pkg::*;
#(
  parameter int RND_W = 4
) (
  input  logic [RND_W-1:0] round_idx,
  input  logic             mode,
  input  logic             active,
  output logic [1:0]       rot_amt,
  output logic             rot_right
);

  always_comb begin
    rot_amt   = 2'd0;
    rot_right = 1'b0;
    if (active) begin
      rot_right = mode;
      rot_amt   = mode ? dec_rot(int'(round_idx)) : enc_rot(int'(round_idx));
    end
  end

endmodule

// File: rtl/des_round_sequencer.sv
// des_round_sequencer: controls one shared DES round datapath.
//   Captures a start request, strobes load_blk, runs NUM_ROUNDS rounds one
//   per clock with the key rotate schedule, strobes final_swap, then holds
//   done until result_ack.
// Ports:
//   clk, rst (async, active low)
//   start, decrypt, abort, result_ack   control inputs
//   step                                 only with DES_SINGLE_STEP_EN defined:
//                                        rounds advance only on step cycles
//   load_blk, round_en, round_idx, rot_amt, rot_right, final_swap
//                                        datapath controls
//   busy, done, S                        status / LED debug
// Build option: DES_SINGLE_STEP_EN.
module des_round_sequencer
  import des_pkg::*;
#(
  parameter int NUM_ROUNDS = NUM_ROUNDS_DEF,
  parameter int RND_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             decrypt,
  input  logic             abort,
  input  logic             result_ack,
`ifdef DES_SINGLE_STEP_EN
  input  logic             step,
`endif
  output logic             load_blk,
  output logic             round_en,
  output logic [RND_W-1:0] round_idx,
  output logic [1:0]       rot_amt,
  output logic             rot_right,
  output logic             final_swap,
  output logic             busy,
  output logic             done,
  output logic [2:0]       S
);

  localparam logic [RND_W-1:0] LAST = RND_W'(NUM_ROUNDS - 1);

  state_t           st, nst;
  logic [RND_W-1:0] idx, nidx;
  logic             mode, nmode;
  logic             adv;

`ifdef DES_SINGLE_STEP_EN
  assign adv = step;
`else
  assign adv = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st   <= S_IDLE;
      idx  <= '0;
      mode <= 1'b0;
    end else begin
      st   <= nst;
      idx  <= nidx;
      mode <= nmode;
    end
  end

  always_comb begin
    nst        = st;
    nidx       = idx;
    nmode      = mode;
    load_blk   = 1'b0;
    round_en   = 1'b0;
    final_swap = 1'b0;
    case (st)
      S_IDLE: if (start) begin
        nst   = S_LOAD;
        nmode = decrypt;
        nidx  = '0;
      end
      S_LOAD: begin
        load_blk = 1'b1;
        nst      = S_ROUND;
      end
      S_ROUND: if (adv) begin
        round_en = 1'b1;
        if (idx == LAST) begin
          nst  = S_FINISH;
          nidx = '0;
        end else begin
          nidx = idx + RND_W'(1);
        end
      end
      S_FINISH: begin
        final_swap = 1'b1;
        nst        = S_DONE;
      end
      // start is deliberately not looked at here: it must be re-presented
      // in IDLE after the result is acknowledged.
      S_DONE:  if (result_ack) nst = S_IDLE;
      S_ERR:   nst = S_IDLE;
      default: nst = S_ERR;
    endcase
    // abort overrides every transition, but only while work is in flight
    if (abort && (st == S_LOAD || st == S_ROUND || st == S_FINISH)) begin
      nst  = S_IDLE;
      nidx = '0;
    end
  end

  des_key_sched_rom #(.RND_W(RND_W)) u_rom (
    .round_idx (idx),
    .mode      (mode),
    .active    (st == S_ROUND),
    .rot_amt   (rot_amt),
    .rot_right (rot_right)
  );

  assign round_idx = idx;
  assign busy      = (st != S_IDLE);
  assign done      = (st == S_DONE);
  assign S         = st;

endmodule

// File: tb/tb_des_round_sequencer.sv
// tb_des_round_sequencer: randomized directed bench with a phase-based model.
// Each operation is modelled by the cycle offset k since start was sampled:
// k=1 load, k=2..N+1 rounds (idx=k-2), k=N+2 final swap, k>=N+3 done.
module tb_des_round_sequencer;

  localparam int N = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0, decrypt = 1'b0, abort = 1'b0, result_ack = 1'b0;
`ifdef DES_SINGLE_STEP_EN
  logic       step = 1'b1;
`endif
  logic       load_blk, round_en, rot_right, final_swap, busy, done;
  logic [3:0] round_idx;
  logic [1:0] rot_amt;
  logic [2:0] S;

  int n_tests = 0;
  int n_fail  = 0;

  des_round_sequencer #(.NUM_ROUNDS(N), .RND_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .decrypt    (decrypt),
    .abort      (abort),
    .result_ack (result_ack),
`ifdef DES_SINGLE_STEP_EN
    .step       (step),
`endif
    .load_blk   (load_blk),
    .round_en   (round_en),
    .round_idx  (round_idx),
    .rot_amt    (rot_amt),
    .rot_right  (rot_right),
    .final_swap (final_swap),
    .busy       (busy),
    .done       (done),
    .S          (S)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Key schedule straight from the rotate rules.
  function automatic logic [1:0] ref_rot(input bit dec, input int idx);
    if (dec && idx == 0) return 2'd0;
    if (idx == 0 || idx == 1 || idx == 8 || idx == 15) return 2'd1;
    return 2'd2;
  endfunction

  task automatic check(input string tag, input logic [2:0] s, input bit bsy,
                       input bit dn, input bit ld, input bit ren, input bit chk_idx,
                       input int idx, input logic [1:0] ra, input bit rr, input bit fs);
    logic [14:0] e, o;
    e = {s, bsy, dn, ld, ren, (chk_idx ? 4'(idx) : 4'd0), ra, rr, fs};
    o = {S, busy, done, load_blk, round_en, (chk_idx ? round_idx : 4'd0),
         rot_amt, rot_right, final_swap};
    n_tests++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // ph: 0 idle, 1 load, 2 round, 3 finish, 4 done
  task automatic chk(input string tag, input int ph, input int idx, input bit dec,
                     input bit ren);
    check(tag, 3'(ph), ph != 0, ph == 4, ph == 1, ren, ph == 2, idx,
          (ph == 2) ? ref_rot(dec, idx) : 2'd0, (ph == 2) && dec, ph == 3);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation. abort_k: cycle offset at which to abort (0 = never).
  // ack_wait: DONE cycles before result_ack (raised together with start).
  task automatic run_op(input string nm, input bit dec, input int abort_k,
                        input int ack_wait);
    int k, ph, idx, dwait;
    bit fin;
    start = 1'b1; decrypt = dec; abort = 1'b0; result_ack = 1'b0;
    #1;
    chk({nm, "_idle_start"}, 0, 0, dec, 1'b0);
    tick();
    k = 1; dwait = 0; fin = 1'b0;
    while (!fin) begin
      if (k == 1)          ph = 1;
      else if (k <= N + 1) ph = 2;
      else if (k == N + 2) ph = 3;
      else                 ph = 4;
      idx = (ph == 2) ? k - 2 : 0;
      // mid-operation decrypt changes and DONE-state start/abort are ignored
      decrypt    = 1'($urandom_range(0, 1));
      start      = (ph == 4) ? 1'($urandom_range(0, 1)) : 1'b0;
      abort      = (k == abort_k) || (ph == 4 && $urandom_range(0, 3) == 0);
      result_ack = (ph == 4 && dwait == ack_wait);
      if (result_ack) start = 1'b1;
      #1;
      chk($sformatf("%s_k%0d", nm, k), ph, idx, dec, ph == 2);
      if (k == abort_k || result_ack) fin = 1'b1;
      if (ph == 4) dwait++;
      k++;
      if (k > 200) fin = 1'b1;
      tick();
    end
    start = 1'b0; abort = 1'b0; result_ack = 1'b0;
    #1;
    chk({nm, "_back_idle"}, 0, 0, dec, 1'b0);
    tick();
    chk({nm, "_no_reload"}, 0, 0, dec, 1'b0);
  endtask

  initial begin
    int ak;
    #3;
    check("reset", 3'd0, 0, 0, 0, 0, 1, 0, 2'd0, 0, 0);
    rst = 1'b1;
    tick();
    check("post_reset", 3'd0, 0, 0, 0, 0, 1, 0, 2'd0, 0, 0);

    run_op("enc", 1'b0, 0, 3);
    run_op("dec", 1'b1, 0, 0);
    run_op("abort_r7", 1'b0, 9, 0);
    run_op("fresh", 1'b0, 0, 1);
    run_op("abort_load", 1'b1, 1, 0);
    run_op("abort_fin", 1'b1, N + 2, 0);
    run_op("abort_last", 1'b0, N + 1, 0);

    for (int r = 0; r < 8; r++) begin
      ak = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, N + 2)) : 0;
      run_op($sformatf("rnd%0d", r), 1'($urandom_range(0, 1)), ak,
             int'($urandom_range(0, 4)));
    end

    // async reset in the middle of the rounds
    start = 1'b1; decrypt = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    chk("pre_rst_round", 2, 5, 1'b1, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("async_rst", 3'd0, 0, 0, 0, 0, 1, 0, 2'd0, 0, 0);
    tick();
    check("rst_held", 3'd0, 0, 0, 0, 0, 1, 0, 2'd0, 0, 0);
    rst = 1'b1;
    tick();
    run_op("after_rst", 1'b1, 0, 2);

`ifdef DES_SINGLE_STEP_EN
    begin
      int sidx;
      start = 1'b1; decrypt = 1'b0; step = 1'b0;
      tick();
      start = 1'b0;
      #1;
      chk("step_load", 1, 0, 1'b0, 1'b0);
      tick();
      sidx = 0;
      for (int c = 0; c < 15; c++) begin
        step = (c % 5 == 2);
        #1;
        chk($sformatf("step_c%0d", c), 2, sidx, 1'b0, step);
        if (step) sidx++;
        tick();
      end
      step = 1'b0;
      #1;
      chk("step_idx3", 2, 3, 1'b0, 1'b0);
      abort = 1'b1;
      tick();
      abort = 1'b0; step = 1'b1;
      #1;
      chk("step_abort", 0, 0, 1'b0, 1'b0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
